// File: rtl/usb4_lane_pkg.sv
// -----------------------------------------------------------------------------
// usb4_lane_pkg
// Shared definitions for the USB4 logical-layer lane path. The lane serializer
// and the lane deserializer both use these.
//   - frame length constants (8 / 66 / 132 bits) and the lane word width
//   - gen_speed encodings
//   - frame_len_of(): maps a gen_speed code to its frame length in bits
// -----------------------------------------------------------------------------
package usb4_lane_pkg;

    localparam int GEN_LEN_8   = 8;
    localparam int GEN_LEN_132 = 132;
    localparam int GEN_LEN_66  = 66;
    localparam int LANE_WORD_W = 132;

    // Width of a frame-length value. It must hold GEN_LEN_132.
    localparam int LEN_W = 8;

    localparam logic [1:0] GEN_SPEED_8     = 2'b00;
    localparam logic [1:0] GEN_SPEED_132   = 2'b01;
    localparam logic [1:0] GEN_SPEED_66    = 2'b10;
    localparam logic [1:0] GEN_SPEED_8_ALT = 2'b11;

    function automatic logic [LEN_W-1:0] frame_len_of(input logic [1:0] gen_speed);
        logic [LEN_W-1:0] len;
        case (gen_speed)
            GEN_SPEED_132:   len = LEN_W'(GEN_LEN_132);
            GEN_SPEED_66:    len = LEN_W'(GEN_LEN_66);
            GEN_SPEED_8_ALT: len = LEN_W'(GEN_LEN_8);
            default:         len = LEN_W'(GEN_LEN_8);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/lanes_deserializer_lane_shift_in.sv
// -----------------------------------------------------------------------------
// lane_shift_in
// This is a per-lane bit-insert register. Each enabled clock writes one serial
// bit at position idx. When start is high, the write goes to bit 0 and every
// other bit is cleared, so a new frame never carries bits over from the
// previous one.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   clear        synchronous flush of the register (used while the lane is disabled)
//   wr_en        write the sampled bit this cycle
//   start        frame start: the register becomes {0..., bit_in}
//   idx          bit position to write
//   bit_in       sampled serial bit
//   word         registered partial word
//   word_next    the word as it will be after this cycle's write (combinational)
// -----------------------------------------------------------------------------
module lane_shift_in
    import usb4_lane_pkg::*;
#(
    parameter int MAX_W = LANE_WORD_W,
    parameter int CNT_W = LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic             start,
    input  logic [CNT_W-1:0] idx,
    input  logic             bit_in,
    output logic [MAX_W-1:0] word,
    output logic [MAX_W-1:0] word_next
);

    // The top level needs the completed word on the same edge that writes the
    // last bit. For that reason the post-write value is exported, in addition
    // to the register itself.
    always_comb begin
        word_next = start ? '0 : word;
        for (int i = 0; i < MAX_W; i++) begin
            if (idx == CNT_W'(i)) begin
                word_next[i] = bit_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= '0;
        end else if (clear) begin
            word <= '0;
        end else if (wr_en) begin
            word <= word_next;
        end
    end

endmodule

// File: rtl/lanes_deserializer.sv
// -----------------------------------------------------------------------------
// lanes_deserializer
// This is the receive-side deserializer for two USB4 lanes. Each lane is
// sampled one bit per clock, LSB first. The bits are assembled into a
// frame_len-bit word. gen_speed selects the frame length and is latched at
// every frame start. The two lanes run in lockstep: they share one bit
// counter and one valid strobe.
// Ports:
//   clk, rst                        clock; asynchronous active-high reset
//   enable                          low = flush the partial frame and idle
//   gen_speed                       frame length: 00/11 -> 8, 01 -> 132, 10 -> 66
//   Lane_0_rx_in, Lane_1_rx_in      serial lane bits
//   Lane_0_rx_out, Lane_1_rx_out    assembled words; held between frames
//   rx_valid                        one-cycle pulse when both words update
//   enable_descr                    descrambler enable, high while deserializing
//   descr_rst                       descrambler seed reset, high at frame start
// -----------------------------------------------------------------------------
module lanes_deserializer
    import usb4_lane_pkg::*;
#(
    parameter int MAX_W = LANE_WORD_W,
    parameter int CNT_W = LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       gen_speed,
    input  logic             Lane_0_rx_in,
    input  logic             Lane_1_rx_in,
    output logic [MAX_W-1:0] Lane_0_rx_out,
    output logic [MAX_W-1:0] Lane_1_rx_out,
    output logic             rx_valid,
    output logic             enable_descr,
    output logic             descr_rst
);

    logic [CNT_W-1:0] bit_idx;
    logic [CNT_W-1:0] frame_len;
    logic             frame_start;
    logic             frame_last;
    logic [MAX_W-1:0] lane0_word;
    logic [MAX_W-1:0] lane1_word;
    logic [MAX_W-1:0] lane0_next;
    logic [MAX_W-1:0] lane1_next;

    // This forces every bit at or above the frame length to zero. A valid
    // frame never writes those positions. The mask still guarantees that a
    // short frame never exposes stale upper bits.
    function automatic logic [MAX_W-1:0] mask_word(input logic [MAX_W-1:0] word,
                                                   input logic [CNT_W-1:0] len);
        logic [MAX_W-1:0] masked;
        masked = word;
        for (int i = 0; i < MAX_W; i++) begin
            if (CNT_W'(i) >= len) begin
                masked[i] = 1'b0;
            end
        end
        return masked;
    endfunction

    assign frame_start = (bit_idx == '0);
    // The minimum frame length is 8. Because of this, the last-bit test never
    // fires together with frame_start, even though frame_len is still the old
    // latched value at that point.
    assign frame_last  = (bit_idx == frame_len - CNT_W'(1));
    assign descr_rst   = frame_start && enable && !rst;

    lane_shift_in #(.MAX_W(MAX_W), .CNT_W(CNT_W)) u_lane0 (
        .clk       (clk),
        .rst       (rst),
        .clear     (!enable),
        .wr_en     (enable),
        .start     (frame_start),
        .idx       (bit_idx),
        .bit_in    (Lane_0_rx_in),
        .word      (lane0_word),
        .word_next (lane0_next)
    );

    lane_shift_in #(.MAX_W(MAX_W), .CNT_W(CNT_W)) u_lane1 (
        .clk       (clk),
        .rst       (rst),
        .clear     (!enable),
        .wr_en     (enable),
        .start     (frame_start),
        .idx       (bit_idx),
        .bit_in    (Lane_1_rx_in),
        .word      (lane1_word),
        .word_next (lane1_next)
    );

    // The registered partial words are only needed inside the sub-modules.
    // The top level uses the post-write values.
    logic unused_words;
    assign unused_words = ^{lane0_word, lane1_word};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx       <= '0;
            frame_len     <= CNT_W'(GEN_LEN_8);
            rx_valid      <= 1'b0;
            enable_descr  <= 1'b0;
            Lane_0_rx_out <= '0;
            Lane_1_rx_out <= '0;
        end else if (!enable) begin
            // The partial frame is dropped. The last completed words stay visible.
            bit_idx      <= '0;
            rx_valid     <= 1'b0;
            enable_descr <= 1'b0;
        end else begin
            enable_descr <= 1'b1;
            rx_valid     <= 1'b0;
            if (frame_start) begin
                // A gen_speed change takes effect only here. A frame that has
                // already started keeps its length.
                frame_len <= CNT_W'(frame_len_of(gen_speed));
                bit_idx   <= CNT_W'(1);
            end else if (frame_last) begin
                Lane_0_rx_out <= mask_word(lane0_next, frame_len);
                Lane_1_rx_out <= mask_word(lane1_next, frame_len);
                rx_valid      <= 1'b1;
                bit_idx       <= '0;
            end else begin
                bit_idx <= bit_idx + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lanes_deserializer.sv
// -----------------------------------------------------------------------------
// tb_lanes_deserializer
// Directed, self-checking bench for lanes_deserializer. The expected words are
// pushed to a scoreboard when a frame is driven. They are popped and compared
// whenever rx_valid is seen.
// -----------------------------------------------------------------------------
module tb_lanes_deserializer;

    localparam int W = 132;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [1:0]   gen_speed;
    logic         l0_in;
    logic         l1_in;
    logic [W-1:0] l0_out;
    logic [W-1:0] l1_out;
    logic         rx_valid;
    logic         enable_descr;
    logic         descr_rst;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] sb0[$];
    logic [W-1:0] sb1[$];

    logic [W-1:0] prev0;
    logic [W-1:0] prev1;
    logic [W-1:0] alt;

    always #5 clk = ~clk;

    lanes_deserializer #(.MAX_W(W), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .gen_speed     (gen_speed),
        .Lane_0_rx_in  (l0_in),
        .Lane_1_rx_in  (l1_in),
        .Lane_0_rx_out (l0_out),
        .Lane_1_rx_out (l1_out),
        .rx_valid      (rx_valid),
        .enable_descr  (enable_descr),
        .descr_rst     (descr_rst)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // These checks run after an edge. They test the valid strobe and, on a
    // valid pulse, compare both output words with the oldest expected entry.
    task automatic post_edge(input logic exp_valid);
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        chk("rx_valid", rx_valid, exp_valid);
        if (rx_valid === 1'b1) begin
            chk("sb_level", sb0.size() != 0, 1);
            if (sb0.size() != 0) begin
                e0 = sb0.pop_front();
                e1 = sb1.pop_front();
                chk("lane0_word", l0_out, e0);
                chk("lane1_word", l1_out, e1);
            end
        end
    endtask

    // This drives one full frame. sw_at >= 0 changes gen_speed to sw_speed at
    // that bit of the frame.
    task automatic send_frame(input logic [W-1:0] w0, input logic [W-1:0] w1, input int len,
                              input int sw_at, input logic [1:0] sw_speed);
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        for (int i = 0; i < W; i++) begin
            e0[i] = (i < len) ? w0[i] : 1'b0;
            e1[i] = (i < len) ? w1[i] : 1'b0;
        end
        sb0.push_back(e0);
        sb1.push_back(e1);
        for (int i = 0; i < len; i++) begin
            if (i == sw_at) gen_speed = sw_speed;
            l0_in = w0[i];
            l1_in = w1[i];
            #1;
            chk("descr_rst", descr_rst, (i == 0));
            @(posedge clk);
            #1;
            chk("enable_descr", enable_descr, 1);
            post_edge(i == len - 1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        gen_speed = 2'b00;
        l0_in     = 1'b0;
        l1_in     = 1'b0;
        #2;
        chk("rst_lane0", l0_out, 0);
        chk("rst_lane1", l1_out, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_en_descr", enable_descr, 0);
        chk("rst_descr_rst", descr_rst, 0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("idle_valid", rx_valid, 0);
        end

        // Test: gen_speed 00, two back-to-back 8-bit frames.
        enable    = 1'b1;
        gen_speed = 2'b00;
        send_frame(W'(8'hA5), W'(8'h3C), 8, -1, 2'b00);
        chk("a5_const", l0_out, W'(8'hA5));
        chk("3c_const", l1_out, W'(8'h3C));
        send_frame(rnd_word(), rnd_word(), 8, -1, 2'b00);

        // Test: gen_speed 11 is also an 8-bit frame.
        gen_speed = 2'b11;
        send_frame(rnd_word(), rnd_word(), 8, -1, 2'b11);

        // Test: gen_speed 10, 66-bit frames with an alternating pattern on lane 0.
        gen_speed = 2'b10;
        alt = '0;
        for (int i = 0; i < 66; i++) alt[i] = i[0];
        send_frame(alt, rnd_word(), 66, -1, 2'b10);
        chk("alt_const", l0_out, {{(W-68){1'b0}}, 68'h2_AAAA_AAAA_AAAA_AAAA});
        send_frame(rnd_word(), rnd_word(), 66, -1, 2'b10);

        // Test: gen_speed 01, back-to-back random 132-bit words.
        gen_speed = 2'b01;
        repeat (3) send_frame(rnd_word(), rnd_word(), 132, -1, 2'b01);

        // Test: switch 01 -> 00 at bit 40. The current frame stays 132 bits.
        send_frame(rnd_word(), rnd_word(), 132, 40, 2'b00);
        send_frame(rnd_word(), rnd_word(), 8, -1, 2'b00);
        send_frame(rnd_word(), rnd_word(), 8, -1, 2'b00);

        // Test: enable dropped at bit 5 of an 8-bit frame, restored 3 cycles later.
        prev0 = l0_out;
        prev1 = l1_out;
        for (int i = 0; i < 5; i++) begin
            l0_in = 1'b1;
            l1_in = 1'b1;
            #1;
            chk("part_descr_rst", descr_rst, (i == 0));
            @(posedge clk);
            #1;
            chk("part_valid", rx_valid, 0);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("off_descr_rst", descr_rst, 0);
            @(posedge clk);
            #1;
            chk("off_valid", rx_valid, 0);
            chk("off_en_descr", enable_descr, 0);
            chk("off_hold0", l0_out, prev0);
            chk("off_hold1", l1_out, prev1);
        end
        enable = 1'b1;
        send_frame(W'(8'hFF), W'(8'h81), 8, -1, 2'b00);

        // Test: asynchronous reset in the middle of a frame, then 20 idle cycles.
        l0_in = 1'b1;
        l1_in = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_lane0", l0_out, 0);
        chk("arst_lane1", l1_out, 0);
        chk("arst_valid", rx_valid, 0);
        chk("arst_en_descr", enable_descr, 0);
        chk("arst_descr_rst", descr_rst, 0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle20_valid", rx_valid, 0);
            chk("idle20_lane0", l0_out, 0);
            chk("idle20_descr_rst", descr_rst, 0);
        end
        chk("sb_empty", sb0.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
